wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning max accepted-but-unacked requests (range 1..15).
REQ-002 SHALL have ports, listed in the order below; m{0,1} means one port per master with an identical definition:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- m{0,1}_addr_i  input  32  master address.
- m{0,1}_data_i  input  32  master write data.
- m{0,1}_data_o  output  32  read data to master.
- m{0,1}_sel_i  input  4  byte selects.
- m{0,1}_cyc_i  input  1  bus cycle request/hold.
- m{0,1}_stb_i  input  1  request strobe.
- m{0,1}_cti_i  input  3  cycle type (010 incrementing, 111 end).
- m{0,1}_we_i  input  1  write enable.
- m{0,1}_ack_o  output  1  response to master.
- m{0,1}_stall_o  output  1  request not accepted this cycle.
- s_addr_o, s_data_o  output  32 each  muxed address and write data to slave.
- s_sel_o  output  4  muxed byte selects.
- s_cti_o  output  3  muxed cycle type.
- s_we_o, s_cyc_o, s_stb_o  output  1 each  muxed controls to slave.
- s_data_i  input  32  slave read data.
- s_ack_i, s_stall_i  input  1 each  slave response and stall.

Function
REQ-003 SHALL implement two states, IDLE and BUSY, plus a 1-bit owner register and a 1-bit last-granted register.
REQ-004 IDLE: all m*_stall_o=1, all m*_ack_o=0, s_cyc_o=0, s_stb_o=0.
REQ-005 IDLE->BUSY on the edge where any m*_cyc_i=1; grant is visible from the next cycle (1-cycle arbitration latency).
REQ-006 Only one master requesting: that master becomes owner.
REQ-007 Both requesting: owner = !last_granted (round-robin); last_granted updates to the new owner on the grant edge.
REQ-008 BUSY: s_addr/data/sel/cti/we_o = owner's inputs; s_cyc_o = owner cyc_i.
REQ-009 BUSY: s_stb_o = owner stb_i & !full, where full = (outstanding == MAX_OUTSTANDING).
REQ-010 Owner stall_o = s_stall_i | full; non-owner stall_o = 1 at all times.
REQ-011 A request counts as accepted when s_stb_o & !s_stall_i; outstanding +1 on accept, -1 on s_ack_i, unchanged when both occur in the same cycle; 4-bit counter.
REQ-012 s_ack_i while outstanding==0 SHALL be ignored: not forwarded, no decrement (no underflow).
REQ-013 Owner ack_o = s_ack_i & (outstanding!=0) & BUSY; owner data_o = s_data_i; non-owner ack_o=0, data_o=0.
REQ-014 BUSY->IDLE when owner cyc_i=0 and outstanding==0; the other master's pending cyc_i is granted from the following cycle (one idle cycle between owners).
REQ-015 Owner drops cyc_i while outstanding>0 (abort): go to IDLE next edge; outstanding cleared to 0; later s_ack_i discarded per REQ-012.
REQ-016 Grant SHALL NOT change while the owner holds cyc_i, including across a cti=010 burst; no burst length is enforced.
REQ-017 Non-owner inputs SHALL have no effect on slave outputs or on the counter.

Reset
REQ-018 rst_ni=0 SHALL asynchronously force state=IDLE, owner=0, last_granted=1 (m0 wins the first tie), outstanding=0.
REQ-019 While in reset, outputs SHALL be per REQ-004; data outputs SHALL be 0.
REQ-020 Reset mid-transaction SHALL drop all outstanding state without generating any ack.

Verification
REQ-021 Reset release, then m0 and m1 raise cyc+stb on the same edge -> m0 granted next cycle; m1_stall_o=1 until m0 drops cyc and its acks drain.
REQ-022 m0 issues a burst of 8 (cti=010 x7, then 111) while m1 requests -> all 8 beats reach the slave contiguously; m1 is granted only after the 8th ack and one idle cycle.
REQ-023 MAX_OUTSTANDING=2, slave holds ack -> after 2 accepts m0_stall_o=1 and s_stb_o=0; one s_ack_i -> stb passes again on the next cycle.
REQ-024 Accept and s_ack_i in the same cycle with outstanding=1 -> outstanding stays 1; s_ack_i with outstanding=0 -> no m*_ack_o.
REQ-025 Random s_stall_i (1 in 4) and ack delay 0..3 cycles, 1000 mixed reads/writes from both masters -> read data matches a memory model; every accepted request is acked exactly once to its issuing master.
REQ-026 rst_ni=0 asserted with outstanding=3 -> outputs reach their reset values immediately; no ack issued after reset release.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone pipelined arbiter in front of a single slave.
//
// Ports:
//   clk_i, rst_ni            clock and asynchronous active-low reset
//   m{0,1}_addr_i/data_i     master address and write data
//   m{0,1}_sel_i/cti_i/we_i  master byte selects, cycle type, write enable
//   m{0,1}_cyc_i/stb_i       master bus cycle and request strobe
//   m{0,1}_data_o/ack_o      read data and acknowledge back to each master
//   m{0,1}_stall_o           request not accepted this cycle
//   s_*_o                    owner's request muxed onto the slave bus
//   s_data_i/ack_i/stall_i   slave response
//
// Ownership is decided in IDLE (round-robin on a tie) and held for as long as
// the owner keeps cyc asserted. A 4-bit counter tracks accepted-but-unacked
// requests; the owner is stalled once MAX_OUTSTANDING are in flight.
module wb_arbiter2 #(
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [2:0]  m0_cti_i,
    input  logic        m0_we_i,
    output logic        m0_ack_o,
    output logic        m0_stall_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [2:0]  m1_cti_i,
    input  logic        m1_we_i,
    output logic        m1_ack_o,
    output logic        m1_stall_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic [2:0]  s_cti_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_stall_i
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [3:0] outst_q, outst_d;

    logic own_cyc, own_stb, own_stb_gated, own_ack, own_stall, full, accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // m0 wins the first tie
            outst_q <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            outst_q <= outst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        outst_d    = outst_q;
        s_addr_o   = '0;
        s_data_o   = '0;
        s_sel_o    = '0;
        s_cti_o    = '0;
        s_we_o     = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_data_o  = '0;
        m1_data_o  = '0;

        own_cyc       = owner_q ? m1_cyc_i : m0_cyc_i;
        own_stb       = owner_q ? m1_stb_i : m0_stb_i;
        full          = (outst_q == MaxOut);
        own_stb_gated = own_stb & ~full;
        own_stall     = s_stall_i | full;
        // An ack with nothing in flight is stale (e.g. after an abort) and dropped
        own_ack       = s_ack_i & (outst_q != 4'd0);
        accept        = own_stb_gated & ~s_stall_i;

        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i | m1_cyc_i) begin
                    state_d = StBusy;
                    owner_d = (m0_cyc_i & m1_cyc_i) ? ~last_q : m1_cyc_i;
                    last_d  = owner_d;
                end
            end
            StBusy: begin
                s_addr_o = owner_q ? m1_addr_i : m0_addr_i;
                s_data_o = owner_q ? m1_data_i : m0_data_i;
                s_sel_o  = owner_q ? m1_sel_i  : m0_sel_i;
                s_cti_o  = owner_q ? m1_cti_i  : m0_cti_i;
                s_we_o   = owner_q ? m1_we_i   : m0_we_i;
                s_cyc_o  = own_cyc;
                s_stb_o  = own_stb_gated;
                if (owner_q) begin
                    m1_stall_o = own_stall;
                    m1_ack_o   = own_ack;
                    m1_data_o  = s_data_i;
                end else begin
                    m0_stall_o = own_stall;
                    m0_ack_o   = own_ack;
                    m0_data_o  = s_data_i;
                end
                // Dropping cyc releases the bus; any in-flight requests are abandoned
                if (!own_cyc) begin
                    state_d = StIdle;
                    outst_d = 4'd0;
                end else if (accept && !own_ack) begin
                    outst_d = outst_q + 4'd1;
                end else if (!accept && own_ack) begin
                    outst_d = outst_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int unsigned MAXO = 2;
    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0BB0;
    localparam logic [31:0] BurstBase = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] m_addr [2];
    logic [31:0] m_wdat [2];
    logic [31:0] m_rdat [2];
    logic [3:0]  m_sel  [2];
    logic [2:0]  m_cti  [2];
    logic        m_cyc  [2];
    logic        m_stb  [2];
    logic        m_we   [2];
    logic        m_ack  [2];
    logic        m_stall[2];
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_stall_i;

    // Slave inputs come either from the directed steps or the slave model
    logic        slave_auto = 1'b0;
    logic        man_ack = 1'b0, man_stall = 1'b0;
    logic [31:0] man_data = '0;
    logic        sl_ack = 1'b0, sl_stall = 1'b0;
    logic [31:0] sl_data = '0;
    assign s_ack_i   = slave_auto ? sl_ack   : man_ack;
    assign s_stall_i = slave_auto ? sl_stall : man_stall;
    assign s_data_i  = slave_auto ? sl_data  : man_data;

    wb_arbiter2 #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_addr_i(m_addr[0]), .m0_data_i(m_wdat[0]), .m0_data_o(m_rdat[0]),
        .m0_sel_i(m_sel[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_cti_i(m_cti[0]),
        .m0_we_i(m_we[0]), .m0_ack_o(m_ack[0]), .m0_stall_o(m_stall[0]),
        .m1_addr_i(m_addr[1]), .m1_data_i(m_wdat[1]), .m1_data_o(m_rdat[1]),
        .m1_sel_i(m_sel[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_cti_i(m_cti[1]),
        .m1_we_i(m_we[1]), .m1_ack_o(m_ack[1]), .m1_stall_o(m_stall[1]),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {logic [31:0] data; logic rd; logic m;} exp_t;
    typedef struct packed {logic [31:0] data; int due;} rsp_t;

    exp_t        sb_q [$];
    rsp_t        rsp_q[$];
    logic [31:0] rmem [16];
    logic [31:0] smem [16];
    int          n_pass = 0, n_total = 0;
    int          cyc_n = 0;
    bit          sb_on = 1'b0, eng_on = 1'b0, rnd_stall = 1'b0;
    bit          acc_f [2];
    int          pend [2];
    int          rem  [2];
    int          budget = 0, acc_cnt = 0, ack_cnt = 0, beat = 0;

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        for (int b = 0; b < 4; b++) if (sel[b]) old[b*8 +: 8] = nw[b*8 +: 8];
        return old;
    endfunction

    // Slave model: accepts on stb & !stall, acks in order 1..4 cycles later
    initial begin
        logic [3:0] idx;
        forever begin
            @(negedge clk_i);
            if (slave_auto) begin
                if (s_ack_i && rsp_q.size() > 0) rsp_q.delete(0);
                if (s_cyc_o && s_stb_o && !s_stall_i) begin
                    idx = s_addr_o[5:2];
                    if (s_we_o) smem[idx] = merge(smem[idx], s_data_o, s_sel_o);
                    rsp_q.push_back('{data: smem[idx], due: cyc_n + 1 + $urandom_range(0, 3)});
                end
            end
            @(posedge clk_i);
            #1;
            sl_stall = rnd_stall && ($urandom_range(0, 3) == 0);
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
                sl_ack  = 1'b1;
                sl_data = rsp_q[0].data;
            end else begin
                sl_ack  = 1'b0;
                sl_data = $urandom();
            end
        end
    end

    task automatic new_req(input int m);
        m_addr[m] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        m_we[m]   = 1'($urandom_range(0, 1));
        m_wdat[m] = $urandom();
        m_sel[m]  = m_we[m] ? 4'($urandom_range(1, 15)) : 4'hf;
        m_cti[m]  = (rem[m] > 1) ? 3'b010 : 3'b111;
    endtask

    // Random master behaviour: bursts of 1..6 requests, cyc held until all acked
    task automatic engine();
        int n;
        for (int m = 0; m < 2; m++) begin
            if (acc_f[m]) begin
                rem[m]--;
                if (rem[m] > 0) new_req(m);
                else m_stb[m] = 1'b0;
            end
            if (m_cyc[m] && rem[m] == 0 && pend[m] == 0) begin
                m_cyc[m] = 1'b0;
            end else if (!m_cyc[m] && budget > 0 && $urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(1, 6));
                if (n > budget) n = budget;
                budget -= n;
                rem[m]   = n;
                m_cyc[m] = 1'b1;
                m_stb[m] = 1'b1;
                new_req(m);
            end
        end
    endtask

    // One clock: score acks/accepts at the falling edge, then step stimulus
    task automatic tick();
        exp_t       e;
        logic [3:0] idx;
        @(negedge clk_i);
        for (int m = 0; m < 2; m++) acc_f[m] = m_cyc[m] && m_stb[m] && !m_stall[m];
        if (sb_on) begin
            for (int m = 0; m < 2; m++) begin
                if (m_ack[m]) begin
                    ack_cnt++;
                    if (sb_q.size() == 0) begin
                        chk1("ack_unexpected", m_ack[m], 1'b0);
                    end else begin
                        e = sb_q.pop_front();
                        chk1("ack_master", 1'(m), e.m);
                        if (e.rd) chk32("rd_data", m_rdat[m], e.data);
                        if (pend[m] > 0) pend[m]--;
                    end
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (acc_f[m]) begin
                    idx = m_addr[m][5:2];
                    if (m_we[m]) begin
                        rmem[idx] = merge(rmem[idx], m_wdat[m], m_sel[m]);
                        sb_q.push_back('{data: 32'd0, rd: 1'b0, m: 1'(m)});
                    end else begin
                        sb_q.push_back('{data: rmem[idx], rd: 1'b1, m: 1'(m)});
                    end
                    pend[m]++;
                    acc_cnt++;
                end
            end
        end
        @(posedge clk_i);
        #1;
        if (eng_on) engine();
    endtask

    task automatic clr_m();
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = '0; m_wdat[m] = '0; m_sel[m] = 4'hf; m_cti[m] = 3'b000;
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rmem[i] = '0;
            smem[i] = '0;
        end
        pend[0] = 0; pend[1] = 0; rem[0] = 0; rem[1] = 0;
        clr_m();
        rst_ni = 1'b1;
        #3 rst_ni = 1'b0;
        // Requests and a slave ack present during reset must not leak through
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'h1234;
        man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk_i);
        #1;
        chk1("rst_m0_stall", m_stall[0], 1'b1);
        chk1("rst_m1_stall", m_stall[1], 1'b1);
        chk1("rst_m0_ack", m_ack[0], 1'b0);
        chk1("rst_s_cyc", s_cyc_o, 1'b0);
        chk1("rst_s_stb", s_stb_o, 1'b0);
        chk32("rst_s_addr", s_addr_o, 32'd0);
        chk32("rst_m0_data", m_rdat[0], 32'd0);
        clr_m();
        man_ack = 1'b0;
        rst_ni = 1'b1;
        tick();

        // Simultaneous request after reset: m0 wins, one cycle latency
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = A0; m_we[0] = 1'b1;
        m_wdat[0] = 32'h1111_1111;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = A1;
        #2;
        chk1("arb_latency_stall", m_stall[0], 1'b1);
        chk1("arb_latency_cyc", s_cyc_o, 1'b0);
        tick();
        #2;
        chk1("tie_s_cyc", s_cyc_o, 1'b1);
        chk32("tie_s_addr", s_addr_o, A0);
        chk32("tie_s_data", s_data_o, 32'h1111_1111);
        chk1("tie_s_we", s_we_o, 1'b1);
        chk1("tie_m0_stall", m_stall[0], 1'b0);
        chk1("tie_m1_stall", m_stall[1], 1'b1);
        tick();
        m_stb[0] = 1'b0; man_ack = 1'b1; man_data = 32'hCAFE_0001;
        #2;
        chk1("m0_ack", m_ack[0], 1'b1);
        chk32("m0_rdata", m_rdat[0], 32'hCAFE_0001);
        chk1("m1_no_ack", m_ack[1], 1'b0);
        chk32("m1_no_data", m_rdat[1], 32'd0);
        chk1("m1_wait_stall", m_stall[1], 1'b1);
        tick();
        man_ack = 1'b0; m_cyc[0] = 1'b0;
        #2;
        chk1("m0_drop_m1_stall", m_stall[1], 1'b1);
        tick();
        #2;
        chk1("idle_gap_m1_stall", m_stall[1], 1'b1);
        chk1("idle_gap_s_cyc", s_cyc_o, 1'b0);
        tick();
        #2;
        chk1("m1_grant_stall", m_stall[1], 1'b0);
        chk1("m1_grant_m0_stall", m_stall[0], 1'b1);
        chk32("m1_grant_addr", s_addr_o, A1);
        tick();
        m_stb[1] = 1'b0; man_ack = 1'b1; man_data = 32'h5555_AAAA;
        #2;
        chk1("m1_ack", m_ack[1], 1'b1);
        chk32("m1_rdata", m_rdat[1], 32'h5555_AAAA);
        chk1("m0_no_ack", m_ack[0], 1'b0);
        tick();
        man_ack = 1'b0; m_cyc[1] = 1'b0;
        tick();
        tick();

        // m0 burst of 8 while m1 waits; m1 last owned, so m0 wins this tie
        slave_auto = 1'b1; rnd_stall = 1'b0; sb_on = 1'b1;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = A1; m_we[1] = 1'b0; m_cti[1] = 3'b111;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1; m_sel[0] = 4'hf;
        beat = 0;
        for (int t = 0; t < 100 && beat < 8; t++) begin
            m_addr[0] = BurstBase + 32'(beat) * 4;
            m_wdat[0] = 32'hB000_0000 + 32'(beat);
            m_cti[0]  = (beat == 7) ? 3'b111 : 3'b010;
            #2;
            chk1("burst_m1_stall", m_stall[1], 1'b1);
            if (!m_stall[0]) begin
                chk32("burst_addr", s_addr_o, BurstBase + 32'(beat) * 4);
                beat++;
            end
            tick();
        end
        m_stb[0] = 1'b0;
        chk32("burst_beats", 32'(beat), 32'd8);
        for (int t = 0; t < 50 && pend[0] != 0; t++) begin
            #2;
            chk1("drain_m1_stall", m_stall[1], 1'b1);
            tick();
        end
        chk32("burst_all_acked", 32'(pend[0]), 32'd0);
        m_cyc[0] = 1'b0;
        #2;
        chk1("burst_drop_m1_stall", m_stall[1], 1'b1);
        tick();
        #2;
        chk1("burst_gap_cyc", s_cyc_o, 1'b0);
        chk1("burst_gap_m1_stall", m_stall[1], 1'b1);
        tick();
        #2;
        chk1("burst_m1_grant", m_stall[1], 1'b0);
        chk32("burst_m1_addr", s_addr_o, A1);
        tick();
        m_stb[1] = 1'b0;
        for (int t = 0; t < 20 && pend[1] != 0; t++) tick();
        chk32("burst_m1_acked", 32'(pend[1]), 32'd0);
        m_cyc[1] = 1'b0;
        tick();
        tick();
        sb_on = 1'b0; slave_auto = 1'b0; man_ack = 1'b0; man_stall = 1'b0;

        // Limit of 2 in flight, simultaneous accept+ack, stale ack
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = A1;
        tick();
        #2;
        chk1("lim_c1_stall", m_stall[1], 1'b0);
        tick();
        man_ack = 1'b1;
        #2;
        chk1("lim_c2_ack", m_ack[1], 1'b1);
        chk1("lim_c2_stb", s_stb_o, 1'b1);
        tick();
        man_ack = 1'b0;
        #2;
        chk1("lim_c3_stb", s_stb_o, 1'b1);
        chk1("lim_c3_stall", m_stall[1], 1'b0);
        tick();
        #2;
        chk1("lim_full_stall", m_stall[1], 1'b1);
        chk1("lim_full_stb", s_stb_o, 1'b0);
        tick();
        man_ack = 1'b1;
        #2;
        chk1("lim_c5_ack", m_ack[1], 1'b1);
        chk1("lim_c5_stall", m_stall[1], 1'b1);
        tick();
        man_ack = 1'b0;
        #2;
        chk1("lim_reopen_stb", s_stb_o, 1'b1);
        chk1("lim_reopen_stall", m_stall[1], 1'b0);
        tick();
        m_stb[1] = 1'b0; man_ack = 1'b1;
        #2;
        chk1("lim_drain1", m_ack[1], 1'b1);
        tick();
        #2;
        chk1("lim_drain2", m_ack[1], 1'b1);
        tick();
        #2;
        chk1("stale_ack_dropped", m_ack[1], 1'b0);
        tick();
        man_ack = 1'b0; m_cyc[1] = 1'b0;
        tick();
        tick();

        // Abort with one in flight: later ack must not reach m0
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = A0; m_we[0] = 1'b0;
        tick();
        #2;
        chk1("abort_accept", m_stall[0], 1'b0);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        #2;
        chk1("abort_s_cyc", s_cyc_o, 1'b0);
        tick();
        man_ack = 1'b1;
        #2;
        chk1("abort_idle_ack", m_ack[0], 1'b0);
        chk1("abort_idle_stall", m_stall[0], 1'b1);
        tick();
        m_cyc[0] = 1'b1;
        tick();
        #2;
        chk1("abort_regrant_cyc", s_cyc_o, 1'b1);
        chk1("abort_cleared_ack", m_ack[0], 1'b0);
        tick();
        man_ack = 1'b0; m_cyc[0] = 1'b0;
        tick();
        tick();

        // Tie after m0 owned goes to m1; then reset mid-transaction
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = A0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_addr[1] = A1;
        tick();
        #2;
        chk32("rr_s_addr", s_addr_o, A1);
        chk1("rr_m1_stall", m_stall[1], 1'b0);
        chk1("rr_m0_stall", m_stall[0], 1'b1);
        tick();
        tick();
        #2;
        chk1("rr_full_stall", m_stall[1], 1'b1);
        #1;
        rst_ni = 1'b0; man_ack = 1'b1; man_data = 32'h7777_8888;
        #1;
        chk1("midrst_s_cyc", s_cyc_o, 1'b0);
        chk1("midrst_s_stb", s_stb_o, 1'b0);
        chk1("midrst_m1_stall", m_stall[1], 1'b1);
        chk1("midrst_m1_ack", m_ack[1], 1'b0);
        chk32("midrst_m1_data", m_rdat[1], 32'd0);
        chk32("midrst_s_addr", s_addr_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        #2;
        chk1("postrst_idle_ack", m_ack[1], 1'b0);
        tick();
        #2;
        chk32("postrst_m0_wins", s_addr_o, A0);
        chk1("postrst_m0_ack", m_ack[0], 1'b0);
        chk1("postrst_m1_ack", m_ack[1], 1'b0);
        clr_m();
        man_ack = 1'b0;
        tick();
        tick();

        // Random mixed traffic from both masters against the memory model
        pend[0] = 0; pend[1] = 0; rem[0] = 0; rem[1] = 0;
        acc_cnt = 0; ack_cnt = 0; budget = 1000;
        slave_auto = 1'b1; rnd_stall = 1'b1; sb_on = 1'b1; eng_on = 1'b1;
        for (int i = 0; i < 40000; i++) begin
            if (budget == 0 && !m_cyc[0] && !m_cyc[1]) break;
            tick();
        end
        eng_on = 1'b0;
        tick();
        chk1("rand_finished", m_cyc[0] | m_cyc[1], 1'b0);
        chk32("rand_accepted", 32'(acc_cnt), 32'd1000);
        chk32("rand_acked", 32'(ack_cnt), 32'(acc_cnt));
        chk32("rand_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
